regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles an MDU head entry may wait before the pipeline is stalled (range 1..15).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: wb_valid  in  1  pipeline W-stage register write request (RegWriteW).
REQ-005 SHALL have ports: wb_mem_to_reg  in  1  selects wb_read_data (1) or wb_alu_out (0).
REQ-006 SHALL have ports: wb_read_data  in  32, wb_alu_out  in  32, wb_dest  in  5  W-stage data and destination.
REQ-007 SHALL have ports: mdu_valid  in  1, mdu_result  in  32, mdu_dest  in  5  multi-cycle multiply/divide result offer.
REQ-008 SHALL have ports: mdu_ready  out  1  MDU buffer can accept an entry this cycle.
REQ-009 SHALL have ports: stall_pipe  out  1  pipeline SHALL freeze W stage this cycle.
REQ-010 SHALL have ports: rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32, rf_src  out  1 (0 pipeline, 1 MDU)  registered register-file write port.

Function
REQ-011 SHALL buffer MDU results in a 2-entry FIFO; mdu_ready = (count < 2), combinational from registered count; push on mdu_valid && mdu_ready.
REQ-012 SHALL decide one grant per cycle, priority: stall_pipe -> MDU head; else wb_valid -> pipeline; else FIFO non-empty -> MDU head; else idle.
REQ-013 SHALL register the granted write at the next rising edge: rf_we=1, rf_waddr, rf_wdata, rf_src; idle cycle -> rf_we=0, other outputs hold.
REQ-014 Pipeline data SHALL be wb_mem_to_reg ? wb_read_data : wb_alu_out; latency exactly 1 cycle.
REQ-015 Granted write with destination 0 SHALL produce rf_we=0 but SHALL still consume the grant (pipeline commit / FIFO pop).
REQ-016 While stall_pipe=1, W-stage inputs SHALL NOT be committed; pipeline re-presents them next cycle.
REQ-017 Pop and push in the same cycle SHALL both take effect; count unchanged; pushed entry goes behind head; order strictly FIFO.
REQ-018 No push SHALL occur when count=2 regardless of mdu_valid (MDU holds its result).
REQ-019 A 4-bit wait counter SHALL increment each cycle the FIFO is non-empty and the head is not granted; SHALL clear on pop or when the FIFO is empty.
REQ-020 stall_pipe SHALL equal (wait_cnt == STARVE_LIMIT), derived from registered state only; the MDU head is granted that cycle, counter clears next cycle.
REQ-021 Counter SHALL saturate at STARVE_LIMIT; no wrap-around.

Reset
REQ-022 On rst_n=0 (asynchronous): FIFO empty, count=0, wait_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, stall_pipe=0, mdu_ready=1.
REQ-023 Reset mid-operation SHALL discard buffered MDU entries; no write SHALL issue in the first cycle after deassertion unless granted in that cycle.

Configuration
REQ-024 Macro ARB_STARVE_GUARD_EN: defined -> REQ-019..021 implemented as stated.
REQ-025 Without ARB_STARVE_GUARD_EN: wait counter absent, stall_pipe tied 0, MDU entries drain only in cycles with wb_valid=0; all other behaviour identical.

Verification
REQ-026 Reset then wb_valid=1, mem_to_reg=0, alu_out=3, read_data=1, dest=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=3, rf_src=0.
REQ-027 Same with mem_to_reg=1 -> rf_wdata=1; with dest=0 -> rf_we=0.
REQ-028 wb_valid=0, mdu_valid one cycle with result 0x12345678, dest 9 -> push; next cycle grant; following edge rf_we=1, rf_waddr=9, rf_src=1.
REQ-029 Three back-to-back mdu_valid while wb_valid=1 continuously -> mdu_ready drops after 2 pushes; third entry held by MDU; order preserved on drain.
REQ-030 With guard enabled, STARVE_LIMIT=4, wb_valid=1 continuously, one MDU entry -> stall_pipe=1 exactly in the 5th cycle after push, MDU written, pipeline write re-presented and committed the cycle after.
REQ-031 Assert rst_n=0 with 2 entries buffered -> outputs return to reset values immediately; after release with idle inputs no rf_we pulse.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: W-stage writes vs. a 2-entry MDU result FIFO.
// Define ARB_STARVE_GUARD_EN to enable the MDU starvation guard (wait counter + stall_pipe).
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic        wb_mem_to_reg,
    input  logic [31:0] wb_read_data,
    input  logic [31:0] wb_alu_out,
    input  logic [4:0]  wb_dest,
    input  logic        mdu_valid,
    input  logic [31:0] mdu_result,
    input  logic [4:0]  mdu_dest,
    output logic        mdu_ready,
    output logic        stall_pipe,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_src
);

    logic [1:0][31:0] data_q, data_d;
    logic [1:0][4:0]  dest_q, dest_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;

    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             rf_src_q, rf_src_d;

    logic             fifo_ne, push, pop, grant_wb;
    logic [31:0]      head_data;
    logic [4:0]       head_dest;

    assign fifo_ne   = (count_q != 2'd0);
    assign mdu_ready = (count_q < 2'd2);
    assign push      = mdu_valid && mdu_ready;
    assign head_data = data_q[rd_ptr_q];
    assign head_dest = dest_q[rd_ptr_q];

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;

    assign stall_pipe = (wait_cnt_q == 4'(STARVE_LIMIT));

    // Counts cycles the head waits behind the pipeline; saturates so stall holds until the pop.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!fifo_ne || pop)
            wait_cnt_d = 4'd0;
        else if (wait_cnt_q < 4'(STARVE_LIMIT))
            wait_cnt_d = wait_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= 4'd0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`else
    logic [3:0] unused_limit;
    assign unused_limit = 4'(STARVE_LIMIT);
    assign stall_pipe   = 1'b0;
`endif

    // stall_pipe forces the MDU head; otherwise the pipeline wins and the FIFO takes idle slots.
    assign pop      = fifo_ne && (stall_pipe || !wb_valid);
    assign grant_wb = wb_valid && !stall_pipe;

    always_comb begin
        data_d   = data_q;
        dest_d   = dest_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop);
        if (push) begin
            data_d[wr_ptr_q] = mdu_result;
            dest_d[wr_ptr_q] = mdu_dest;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_src_d   = rf_src_q;
        if (grant_wb) begin
            rf_we_d    = (wb_dest != 5'd0);
            rf_waddr_d = wb_dest;
            rf_wdata_d = wb_mem_to_reg ? wb_read_data : wb_alu_out;
            rf_src_d   = 1'b0;
        end else if (pop) begin
            rf_we_d    = (head_dest != 5'd0);
            rf_waddr_d = head_dest;
            rf_wdata_d = head_data;
            rf_src_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            dest_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            rf_src_q   <= 1'b0;
        end else begin
            data_q     <= data_d;
            dest_q     <= dest_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_src   = rf_src_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0, wb_mem_to_reg = 1'b0;
    logic [31:0] wb_read_data = '0, wb_alu_out = '0;
    logic [4:0]  wb_dest = '0;
    logic        mdu_valid = 1'b0;
    logic [31:0] mdu_result = '0;
    logic [4:0]  mdu_dest = '0;
    logic        mdu_ready, stall_pipe, rf_we, rf_src;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_read_data(wb_read_data), .wb_alu_out(wb_alu_out), .wb_dest(wb_dest),
        .mdu_valid(mdu_valid), .mdu_result(mdu_result), .mdu_dest(mdu_dest),
        .mdu_ready(mdu_ready), .stall_pipe(stall_pipe),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wbv, m2r;
        logic [31:0] rd, alu;
        logic [4:0]  wd;
        logic        mv;
        logic [31:0] mr;
        logic [4:0]  md;
        logic        e_ready, e_stall, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_src;
    } vec_t;

    int passed = 0;
    int total  = 0;

    logic [36:0] q[$];
    int          wt;

    function automatic vec_t mkv(input int wbv, m2r, input logic [31:0] rd, alu, input int wd,
                                 input int mv, input logic [31:0] mr, input int md,
                                 input int er, es, ew, input int ea, input logic [31:0] edat,
                                 input int esrc);
        vec_t v;
        v.wbv = 1'(wbv); v.m2r = 1'(m2r); v.rd = rd; v.alu = alu; v.wd = 5'(wd);
        v.mv = 1'(mv); v.mr = mr; v.md = 5'(md);
        v.e_ready = 1'(er); v.e_stall = 1'(es); v.e_we = 1'(ew);
        v.e_waddr = 5'(ea); v.e_wdata = edat; v.e_src = 1'(esrc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive_idle();
        wb_valid = 1'b0; wb_mem_to_reg = 1'b0; wb_read_data = '0; wb_alu_out = '0;
        wb_dest = '0; mdu_valid = 1'b0; mdu_result = '0; mdu_dest = '0;
    endtask

    task automatic run_cycle(input vec_t v, input string tag);
        @(negedge clk);
        wb_valid = v.wbv; wb_mem_to_reg = v.m2r; wb_read_data = v.rd; wb_alu_out = v.alu;
        wb_dest = v.wd; mdu_valid = v.mv; mdu_result = v.mr; mdu_dest = v.md;
        #1;
        chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(v.e_ready));
        chk({tag, ".stall_pipe"}, 32'(stall_pipe), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(v.e_we));
        if (v.e_we) begin
            chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(v.e_waddr));
            chk({tag, ".rf_wdata"}, rf_wdata, v.e_wdata);
            chk({tag, ".rf_src"}, 32'(rf_src), 32'(v.e_src));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'd0);
        chk({tag, ".rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, ".rf_src"}, 32'(rf_src), 32'd0);
        chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'd1);
        chk({tag, ".stall_pipe"}, 32'(stall_pipe), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        chk_reset_vals(tag);
        rst_n = 1'b1;
        q.delete();
        wt = 0;
    endtask

    // Reference: the MDU buffer is a queue, the wait counter a plain integer.
    task automatic model(inout vec_t v);
        int  n;
        bit  took;
        logic [36:0] e;
        n = q.size();
        took = 1'b0;
        v.e_ready = (n < 2);
        v.e_stall = GUARD && (wt == LIM);
        v.e_we = 1'b0; v.e_waddr = '0; v.e_wdata = '0; v.e_src = 1'b0;
        if (n > 0 && (v.e_stall || !v.wbv)) begin
            e = q.pop_front();
            took = 1'b1;
            v.e_we = (e[36:32] != 5'd0);
            v.e_waddr = e[36:32]; v.e_wdata = e[31:0]; v.e_src = 1'b1;
        end else if (v.wbv) begin
            v.e_we = (v.wd != 5'd0);
            v.e_waddr = v.wd; v.e_wdata = v.m2r ? v.rd : v.alu; v.e_src = 1'b0;
        end
        if (n > 0 && !took) wt = (wt + 1 > LIM) ? LIM : wt + 1;
        else wt = 0;
        if (v.mv && v.e_ready) q.push_back({v.md, v.mr});
    endtask

    vec_t tbl[13];
    vec_t seq[8];

    initial begin
        vec_t v;
        tbl[0]  = mkv(1,0,1,3,5,           0,0,0,            1,0,1,5,3,0);
        tbl[1]  = mkv(1,1,1,3,5,           0,0,0,            1,0,1,5,1,0);
        tbl[2]  = mkv(1,1,1,3,0,           0,0,0,            1,0,0,0,0,0);
        tbl[3]  = mkv(0,0,0,0,0,           1,32'h12345678,9, 1,0,0,0,0,0);
        tbl[4]  = mkv(0,0,0,0,0,           0,0,0,            1,0,1,9,32'h12345678,1);
        tbl[5]  = mkv(1,0,0,32'h101,1,     1,32'hA1,10,      1,0,1,1,32'h101,0);
        tbl[6]  = mkv(1,0,0,32'h102,2,     1,32'hB2,11,      1,0,1,2,32'h102,0);
        tbl[7]  = mkv(1,0,0,32'h103,3,     1,32'hC3,12,      0,0,1,3,32'h103,0);
        tbl[8]  = mkv(1,0,0,32'h104,4,     1,32'hC3,12,      0,0,1,4,32'h104,0);
        tbl[9]  = mkv(0,0,0,0,0,           1,32'hC3,12,      0,0,1,10,32'hA1,1);
        tbl[10] = mkv(0,0,0,0,0,           1,32'hC3,12,      1,0,1,11,32'hB2,1);
        tbl[11] = mkv(0,0,0,0,0,           0,0,0,            1,0,1,12,32'hC3,1);
        tbl[12] = mkv(0,0,0,0,0,           0,0,0,            1,0,0,0,0,0);

        drive_idle();
        do_reset("reset");
        for (int i = 0; i < 13; i++) run_cycle(tbl[i], $sformatf("tbl%0d", i));

        // Starvation: one MDU entry behind a continuously valid pipeline.
        do_reset("reset_starve");
        seq[0] = mkv(1,0,0,32'h50,1, 1,32'hDEAD,7, 1,0,1,1,32'h50,0);
        for (int i = 1; i < 5; i++)
            seq[i] = mkv(1,0,0,32'h50 + i,1 + i, 0,0,0, 1,0,1,1 + i,32'h50 + i,0);
        if (GUARD) begin
            seq[5] = mkv(1,0,0,32'h99,20, 0,0,0, 1,1,1,7,32'hDEAD,1);
            seq[6] = mkv(1,0,0,32'h99,20, 0,0,0, 1,0,1,20,32'h99,0);
            seq[7] = mkv(0,0,0,0,0,       0,0,0, 1,0,0,0,0,0);
        end else begin
            seq[5] = mkv(1,0,0,32'h99,20, 0,0,0, 1,0,1,20,32'h99,0);
            seq[6] = mkv(1,0,0,32'h99,20, 0,0,0, 1,0,1,20,32'h99,0);
            seq[7] = mkv(0,0,0,0,0,       0,0,0, 1,0,1,7,32'hDEAD,1);
        end
        for (int i = 0; i < 8; i++) run_cycle(seq[i], $sformatf("starve%0d", i));

        // Reset while two entries are buffered and a write is on the port.
        do_reset("reset_mid");
        run_cycle(mkv(1,0,0,32'h77,3, 1,32'h1,4, 1,0,1,3,32'h77,0), "mid0");
        run_cycle(mkv(1,0,0,32'h78,6, 1,32'h2,5, 1,0,1,6,32'h78,0), "mid1");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            run_cycle(mkv(0,0,0,0,0, 0,0,0, 1,0,0,0,0,0), $sformatf("post_rst%0d", i));

        do_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            v.wbv = ($urandom_range(0, 3) != 0);
            v.m2r = 1'($urandom_range(0, 1));
            v.rd  = $urandom();
            v.alu = $urandom();
            v.wd  = 5'($urandom_range(0, 31));
            v.mv  = 1'($urandom_range(0, 1));
            v.mr  = $urandom();
            v.md  = 5'($urandom_range(0, 31));
            model(v);
            run_cycle(v, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
